fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction fetch stage of the 5-stage MIPS pipeline, directly upstream of decode.
- Holds the PC and issues single-word reads on the instruction bus, with at most one read outstanding.
- Buffers returned words in a small FIFO and presents pc / pc_plus_4 / instruction / rs / rt to decode over a valid/ready handshake.
- Redirects on the branch and jump decisions from decode and discards any in-flight wrong-path fetch.

Parameters:
- RESET_PC, 32'hBFC0_0000, PC loaded on reset.
- QDEPTH, 2, instruction queue entries; must be a power of two, at least 2.

Ports:
- clk  in  1  clock, rising edge
- resetn  in  1  asynchronous active-low reset
- ireq_valid  out  1  fetch request valid
- ireq_addr  out  32  fetch address, word aligned
- ireq_ready  in  1  bus accepts the request this cycle
- iresp_valid  in  1  read data returned this cycle
- iresp_data  in  32  instruction word
- branch_judge  in  1  taken-branch redirect from decode
- branch_address  in  32  branch target
- jump_judge  in  1  jump redirect from decode
- jump_address  in  32  jump target
- fd_valid  out  1  queue head valid to decode
- fd_ready  in  1  decode accepts the head (low = stall)
- fd_pc  out  32  head PC
- fd_pc_plus_4  out  32  head PC + 4
- fd_instr  out  32  head instruction word
- fd_rs  out  5  fd_instr[25:21]
- fd_rt  out  5  fd_instr[20:16]

Behaviour:
- Reset (async, resetn=0):
  - pc = RESET_PC; queue empty; FSM = IDLE; discard flag = 0.
  - ireq_valid = 0, fd_valid = 0.
  - fd_* outputs are 0 when fd_valid = 0.
- FSM states:
  - IDLE -> REQ when credit > 0, where credit = QDEPTH - occupancy.
  - REQ: ireq_valid = 1 and ireq_addr = pc, both held stable until ireq_ready. On accept, latch req_pc = pc, pc <= pc+4, go to WAIT.
  - WAIT: on iresp_valid, push {req_pc, iresp_data} unless discard = 1; clear discard. Then go to REQ if credit > 0 (counting a pop in the same cycle), else IDLE.
  - A response may return in the cycle after acceptance at the earliest. Back-to-back throughput is one instruction per 2 cycles.
- Credit rule: a request is issued only if a queue slot is reserved for it, so the queue never overflows.
- Dequeue: the head is popped when fd_valid && fd_ready. fd_rs and fd_rt are combinational slices of the head.
- Redirect (branch_judge || jump_judge):
  - branch_judge has priority when both are high.
  - Queue is flushed that cycle; a simultaneous pop is ignored.
  - pc <= target.
  - IDLE: go to REQ next cycle at the target.
  - REQ: the pending address stays stable until accepted. It is then marked discard and the target is requested next.
  - WAIT: discard = 1. If iresp_valid arrives in the same cycle, that word is dropped.
  - In every case the first fd_valid after a redirect carries fd_pc = target.
- Redirect while fd_ready = 0 still flushes.
- A redirect during reset is ignored.
- PC arithmetic is 32-bit with wrap-around: 32'hFFFF_FFFC + 4 = 0.
- Target bits [1:0] are forced to 0.
- Reset asserted mid-request drops all state. An iresp_valid arriving after reset release with no request outstanding is ignored.

Optional Feature:
- FETCH_STATS_EN defined: adds out ports stat_fetched (32) and stat_discarded (32).
  - stat_fetched counts queue pushes.
  - stat_discarded counts dropped responses plus flushed queue entries.
  - Both counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; the block is otherwise identical.

Test Plan:
- Reset, ireq_ready=1, 1-cycle response latency, fd_ready=1 -> addresses BFC00000, BFC00004, BFC00008 in order; fd_pc matches each with fd_pc_plus_4 = fd_pc+4; fd_rs/fd_rt equal the instruction slices.
- fd_ready=0 for 10 cycles -> occupancy reaches QDEPTH=2; ireq_valid stays 0 until a pop; no entry is lost or duplicated.
- jump_judge=1, jump_address=00400020 while in WAIT with a response for BFC00008 due the same cycle -> BFC00008 is never presented; next fd_pc = 00400020.
- ireq_ready held low 3 cycles while branch_judge=1, branch_address=00400100 -> ireq_addr stays stable until accepted; that response is dropped; next request and next fd_pc = 00400100.
- Reset driven low mid-WAIT, then released -> ireq_addr = BFC00000, queue empty, any late response ignored.
- With FETCH_STATS_EN, run scenario 3 -> stat_discarded increments by 1 plus the number of flushed entries; stat_fetched counts pushes only.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus bundle: instruction-bus request/response plus the fetch->decode handshake.
// The master modport is the fetch stage. The slave modport is the memory/decode side.
interface fetch_stage_if;
  // Instruction bus
  logic        ireq_valid;
  logic [31:0] ireq_addr;
  logic        ireq_ready;
  logic        iresp_valid;
  logic [31:0] iresp_data;

  // Fetch -> decode
  logic        fd_valid;
  logic        fd_ready;
  logic [31:0] fd_pc;
  logic [31:0] fd_pc_plus_4;
  logic [31:0] fd_instr;
  logic [4:0]  fd_rs;
  logic [4:0]  fd_rt;

  modport master (
    output ireq_valid,
    output ireq_addr,
    input  ireq_ready,
    input  iresp_valid,
    input  iresp_data,
    output fd_valid,
    input  fd_ready,
    output fd_pc,
    output fd_pc_plus_4,
    output fd_instr,
    output fd_rs,
    output fd_rt
  );

  modport slave (
    input  ireq_valid,
    input  ireq_addr,
    output ireq_ready,
    output iresp_valid,
    output iresp_data,
    input  fd_valid,
    output fd_ready,
    input  fd_pc,
    input  fd_pc_plus_4,
    input  fd_instr,
    input  fd_rs,
    input  fd_rt
  );
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction fetch stage.
// Holds the PC and issues single-word reads with at most one read outstanding. Returned words
// go into a QDEPTH-entry queue that feeds decode. Branch/jump redirects flush the queue and
// discard any wrong-path read still in flight.
// Optional build macro FETCH_STATS_EN adds saturating fetched/discarded counters.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int unsigned QDEPTH   = 2  // power of two, >= 2
) (
  input  logic                 clk,
  input  logic                 resetn,
  fetch_stage_if.master        bus,
  input  logic                 branch_judge,
  input  logic [31:0]          branch_address,
  input  logic                 jump_judge,
  input  logic [31:0]          jump_address
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0]          stat_fetched,
  output logic [31:0]          stat_discarded
`endif
);

  localparam int unsigned PtrW = $clog2(QDEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] QDepthCnt = CntW'(QDEPTH);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e      state_q;
  logic [31:0] pc_q;          // address of the next request to place on the bus
  logic [31:0] req_addr_q;    // address currently presented on the bus
  logic [31:0] req_pc_q;      // address of the read in flight
  logic        ireq_valid_q;
  logic        discard_q;     // in-flight read is wrong-path
  logic        wrong_q;       // pending (not yet accepted) request is wrong-path

  logic        redir;
  logic [31:0] target;
  logic [31:0] pc_eff;

  logic [31:0]     q_pc    [QDEPTH];
  logic [31:0]     q_instr [QDEPTH];
  logic [PtrW-1:0] rd_ptr_q, wr_ptr_q;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        head_valid;
  logic        push;
  logic        pop;
  logic        go_req;
  logic        drop_resp;
  logic [31:0] head_pc;
  logic [31:0] head_instr;
  logic [31:0] fd_instr_w;

  logic        unused_tgt_lsbs;

  // Redirect decode: branch wins over jump, and targets are forced word aligned.
  assign redir           = branch_judge | jump_judge;
  assign target          = branch_judge ? {branch_address[31:2], 2'b00}
                                        : {jump_address[31:2], 2'b00};
  assign pc_eff          = redir ? target : pc_q;
  assign unused_tgt_lsbs = ^{branch_address[1:0], jump_address[1:0]};

  // A pop is ignored when the queue is flushed in the same cycle.
  assign head_valid = (cnt_q != '0);
  assign pop        = head_valid & bus.fd_ready & ~redir;
  assign push       = (state_q == StWait) & bus.iresp_valid & ~discard_q & ~redir;
  assign drop_resp  = (state_q == StWait) & bus.iresp_valid & (discard_q | redir);

  // Next queue occupancy, including this cycle's push, pop and flush.
  always_comb begin
    cnt_d = cnt_q;
    if (redir) begin
      cnt_d = '0;
    end else begin
      if (push) cnt_d = cnt_d + CntW'(1);
      if (pop)  cnt_d = cnt_d - CntW'(1);
    end
  end

  // A new request reserves a queue slot, so the queue cannot overflow.
  assign go_req = (cnt_d < QDepthCnt);

  // Fetch FSM with registered bus request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q      <= StIdle;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      req_pc_q     <= '0;
      ireq_valid_q <= 1'b0;
      discard_q    <= 1'b0;
      wrong_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          pc_q <= pc_eff;
          if (go_req) begin
            state_q      <= StReq;
            ireq_valid_q <= 1'b1;
            req_addr_q   <= pc_eff;
          end
        end
        StReq: begin
          // The presented address stays put until accepted, even across a redirect.
          if (redir) pc_q <= target;
          if (bus.ireq_ready) begin
            state_q      <= StWait;
            ireq_valid_q <= 1'b0;
            req_pc_q     <= req_addr_q;
            discard_q    <= wrong_q | redir;
            wrong_q      <= 1'b0;
            if (!(wrong_q | redir)) pc_q <= req_addr_q + 32'd4;
          end else if (redir) begin
            wrong_q <= 1'b1;
          end
        end
        StWait: begin
          if (bus.iresp_valid) begin
            discard_q <= 1'b0;
            pc_q      <= pc_eff;
            if (go_req) begin
              state_q      <= StReq;
              ireq_valid_q <= 1'b1;
              req_addr_q   <= pc_eff;
            end else begin
              state_q <= StIdle;
            end
          end else if (redir) begin
            discard_q <= 1'b1;
            pc_q      <= target;
          end
        end
        default: begin
          state_q      <= StIdle;
          ireq_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Queue pointers and occupancy; a redirect empties the queue.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (redir) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      cnt_q <= cnt_d;
    end
  end

  // Queue storage; contents are only observable through the valid-gated head.
  always_ff @(posedge clk) begin
    if (push) begin
      q_pc[wr_ptr_q]    <= req_pc_q;
      q_instr[wr_ptr_q] <= bus.iresp_data;
    end
  end

  assign head_pc    = q_pc[rd_ptr_q];
  assign head_instr = q_instr[rd_ptr_q];
  assign fd_instr_w = head_valid ? head_instr : '0;

  assign bus.ireq_valid   = ireq_valid_q;
  assign bus.ireq_addr    = req_addr_q;
  assign bus.fd_valid     = head_valid;
  assign bus.fd_pc        = head_valid ? head_pc : '0;
  assign bus.fd_pc_plus_4 = head_valid ? head_pc + 32'd4 : '0;
  assign bus.fd_instr     = fd_instr_w;
  assign bus.fd_rs        = fd_instr_w[25:21];
  assign bus.fd_rt        = fd_instr_w[20:16];

`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched_q, stat_discarded_q;
  logic [32:0] fetched_sum, discarded_sum;

  assign fetched_sum   = {1'b0, stat_fetched_q} + 33'(push);
  assign discarded_sum = {1'b0, stat_discarded_q} + 33'(drop_resp)
                       + (redir ? 33'(cnt_q) : 33'd0);

  // Saturating event counters.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      stat_fetched_q   <= '0;
      stat_discarded_q <= '0;
    end else begin
      stat_fetched_q   <= fetched_sum[32]   ? 32'hFFFF_FFFF : fetched_sum[31:0];
      stat_discarded_q <= discarded_sum[32] ? 32'hFFFF_FFFF : discarded_sum[31:0];
    end
  end

  assign stat_fetched   = stat_fetched_q;
  assign stat_discarded = stat_discarded_q;
`else
  logic unused_drop_resp;
  assign unused_drop_resp = drop_resp;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: stimulus pushes the expected fetch PCs, a negedge monitor
// pops and compares on every fd handshake, and a bus model answers accepted reads one cycle later.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        resetn;
  logic        branch_judge;
  logic [31:0] branch_address;
  logic        jump_judge;
  logic [31:0] jump_address;
`ifdef FETCH_STATS_EN
  logic [31:0] stat_fetched;
  logic [31:0] stat_discarded;
`endif

  fetch_stage_if ifc ();

  fetch_stage #(
    .RESET_PC(32'hBFC0_0000),
    .QDEPTH  (2)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .bus           (ifc),
    .branch_judge  (branch_judge),
    .branch_address(branch_address),
    .jump_judge    (jump_judge),
    .jump_address  (jump_address)
`ifdef FETCH_STATS_EN
    ,
    .stat_fetched  (stat_fetched),
    .stat_discarded(stat_discarded)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          pop_cnt = 0;
  bit          spurious = 1'b0;
  logic [31:0] exp_q[$];

  // Instruction memory contents as a function of address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[7:2], a[6:2] ^ 5'h0A, a[11:7], a[31:16] ^ a[15:0]};
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pops(input int n, input string name);
    for (int i = 0; i < 200; i++) begin
      if (pop_cnt >= n) break;
      tick();
    end
    n_tests++;
    if (pop_cnt < n) begin
      n_fail++;
      $display("FAIL %s actual=%0d pops required=%0d pops", name, pop_cnt, n);
    end
  endtask

  task automatic wait_accept(input logic [31:0] a, input string name);
    bit found = 1'b0;
    for (int i = 0; i < 100 && !found; i++) begin
      @(negedge clk);
      if (ifc.ireq_valid && ifc.ireq_ready && ifc.ireq_addr == a) found = 1'b1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s actual=timeout required=accept of %h", name, a);
    end
    tick();
  endtask

  // Bus model: one-cycle read latency, plus an optional unsolicited response.
  initial begin
    logic        acc;
    logic [31:0] acc_addr;
    logic        spur;
    ifc.iresp_valid = 1'b0;
    ifc.iresp_data  = '0;
    forever begin
      @(negedge clk);
      acc      = resetn && ifc.ireq_valid && ifc.ireq_ready;
      acc_addr = ifc.ireq_addr;
      spur     = spurious;
      @(posedge clk);
      #1;
      ifc.iresp_valid = acc || spur;
      ifc.iresp_data  = acc ? mem_word(acc_addr) : 32'hDEAD_BEEF;
    end
  end

  // Monitor: every accepted head must match the next expected fetch.
  always @(negedge clk) begin
    logic [31:0] e;
    logic [31:0] ei;
    if (resetn && ifc.fd_valid && ifc.fd_ready && !(branch_judge || jump_judge)) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_pop actual=pc %h required=no entry", ifc.fd_pc);
      end else begin
        e  = exp_q.pop_front();
        ei = mem_word(e);
        check32("fd_pc", ifc.fd_pc, e);
        check32("fd_pc_plus_4", ifc.fd_pc_plus_4, e + 32'd4);
        check32("fd_instr", ifc.fd_instr, ei);
        check32("fd_rs", 32'(ifc.fd_rs), 32'(ei[25:21]));
        check32("fd_rt", 32'(ifc.fd_rt), 32'(ei[20:16]));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
`ifdef FETCH_STATS_EN
    logic [31:0] disc0;
    logic [31:0] fetch0;
`endif
    resetn         = 1'b0;
    ifc.ireq_ready = 1'b1;
    ifc.fd_ready   = 1'b1;
    branch_judge   = 1'b0;
    branch_address = '0;
    jump_judge     = 1'b1;  // redirect while in reset must be ignored
    jump_address   = 32'h1234_5678;
    repeat (2) tick();
    jump_judge = 1'b0;
    check32("rst_ireq_valid", 32'(ifc.ireq_valid), 32'd0);
    check32("rst_fd_valid", 32'(ifc.fd_valid), 32'd0);
    check32("rst_fd_pc", ifc.fd_pc, 32'd0);
    check32("rst_fd_pc_plus_4", ifc.fd_pc_plus_4, 32'd0);
    check32("rst_fd_instr", ifc.fd_instr, 32'd0);
    tick();

    // Straight-line fetch from the reset vector.
    resetn = 1'b1;
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0004);
    exp_q.push_back(32'hBFC0_0008);
    tick();
    check32("first_ireq_valid", 32'(ifc.ireq_valid), 32'd1);
    check32("first_ireq_addr", ifc.ireq_addr, 32'hBFC0_0000);
    wait_pops(3, "seq_pops");

    // Decode stall: queue fills to two entries and fetching stops.
    ifc.fd_ready = 1'b0;
    repeat (10) tick();
    check32("stall_ireq_valid", 32'(ifc.ireq_valid), 32'd0);
    check32("stall_fd_valid", 32'(ifc.fd_valid), 32'd1);
    check32("stall_head_pc", ifc.fd_pc, 32'hBFC0_000C);

    // Drain with the bus blocked; the next request waits at BFC00014.
    ifc.ireq_ready = 1'b0;
    exp_q.push_back(32'hBFC0_000C);
    exp_q.push_back(32'hBFC0_0010);
    ifc.fd_ready = 1'b1;
    wait_pops(5, "drain_pops");
    check32("blocked_ireq_valid", 32'(ifc.ireq_valid), 32'd1);
    check32("blocked_ireq_addr", ifc.ireq_addr, 32'hBFC0_0014);

    // Branch while the request is pending: address holds, its response is discarded.
    branch_judge   = 1'b1;
    branch_address = 32'h0040_0100;
    tick();
    branch_judge = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check32("hold_ireq_valid", 32'(ifc.ireq_valid), 32'd1);
      check32("hold_ireq_addr", ifc.ireq_addr, 32'hBFC0_0014);
      tick();
    end
    exp_q.push_back(32'h0040_0100);
    ifc.ireq_ready = 1'b1;
    wait_accept(32'h0040_0100, "branch_target_req");
    wait_pops(6, "branch_pops");
    ifc.fd_ready = 1'b0;

    // Reset in the middle of a read; queued entry and late response are lost.
    wait_accept(32'h0040_0108, "pre_reset_req");
    resetn = 1'b0;
    exp_q.delete();
    tick();
    check32("midrst_fd_valid", 32'(ifc.fd_valid), 32'd0);
    check32("midrst_ireq_valid", 32'(ifc.ireq_valid), 32'd0);
    tick();
    resetn       = 1'b1;
    spurious     = 1'b1;
    ifc.fd_ready = 1'b1;
    exp_q.push_back(32'hBFC0_0000);
    exp_q.push_back(32'hBFC0_0004);
    exp_q.push_back(32'h0040_0020);
    exp_q.push_back(32'h0040_0024);
    tick();
    spurious = 1'b0;
    check32("rerst_ireq_valid", 32'(ifc.ireq_valid), 32'd1);
    check32("rerst_ireq_addr", ifc.ireq_addr, 32'hBFC0_0000);

    // Jump coinciding with the response for BFC00008: that word must never appear.
    wait_accept(32'hBFC0_0008, "pre_jump_req");
`ifdef FETCH_STATS_EN
    disc0 = stat_discarded;
`endif
    jump_judge   = 1'b1;
    jump_address = 32'h0040_0020;
    tick();
    jump_judge = 1'b0;
`ifdef FETCH_STATS_EN
    check32("stat_disc_jump", stat_discarded, disc0 + 32'd1);
`endif
    wait_pops(10, "jump_pops");
    ifc.fd_ready = 1'b0;

    // Branch and jump together from a full, idle queue; pop in that cycle is ignored.
    repeat (10) tick();
    check32("full_head_pc", ifc.fd_pc, 32'h0040_0028);
`ifdef FETCH_STATS_EN
    disc0  = stat_discarded;
    fetch0 = stat_fetched;
`endif
    branch_judge   = 1'b1;
    branch_address = 32'hFFFF_FFFF;
    jump_judge     = 1'b1;
    jump_address   = 32'h0000_0800;
    ifc.fd_ready   = 1'b1;
    exp_q.push_back(32'hFFFF_FFFC);
    exp_q.push_back(32'h0000_0000);
    tick();
    branch_judge = 1'b0;
    jump_judge   = 1'b0;
`ifdef FETCH_STATS_EN
    check32("stat_disc_flush", stat_discarded, disc0 + 32'd2);
    check32("stat_fetch_flush", stat_fetched, fetch0);
`endif
    check32("prio_ireq_addr", ifc.ireq_addr, 32'hFFFF_FFFC);
    wait_pops(12, "wrap_pops");
    ifc.fd_ready = 1'b0;
    repeat (4) tick();
    check32("exp_left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
